// File: rtl/io_pad_seq_pkg.sv
// Shared definitions for the IO pad bank power sequencer.
//   - FSM state encodings (3-bit)
//   - default settle / stagger cycle counts
//   - bank width helper
package io_pad_seq_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_OFF      = 3'd0;
    localparam seq_state_t ST_WAIT_PWR = 3'd1;
    localparam seq_state_t ST_SETTLE   = 3'd2;
    localparam seq_state_t ST_TX_UP    = 3'd3;
    localparam seq_state_t ST_ACTIVE   = 3'd4;
    localparam seq_state_t ST_TX_DOWN  = 3'd5;

    localparam int unsigned DEF_SETTLE_CYCLES  = 64;
    localparam int unsigned DEF_STAGGER_CYCLES = 16;

    // Total pads in a bank.
    function automatic int unsigned bank_width(input int unsigned ng, input int unsigned gw);
        return ng * gw;
    endfunction

endpackage

// File: rtl/io_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, synchronous reset to 0.
// Ports:
//   clk  in  sampling clock
//   rst  in  synchronous reset, active high
//   d    in  asynchronous input level
//   q    out synchronized level (STAGES cycles of latency)
module io_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; first flop is the only one exposed to metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/io_pad_pwr_seq.sv
// Power/enable sequencer for one IO pad bank.
// Waits for synchronized VDDIO power-good, lets the supply settle, releases isolation
// and receivers, then enables driver groups one at a time to limit switching noise.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   pwr_ok_ai     asynchronous VDDIO power-good
//   seq_start_i   pulse: start power-up (only honoured in OFF)
//   seq_stop_i    pulse: orderly shutdown
//   core_oe_i/ie  per-pad enables from the core
//   pad_oe_o/ie   gated enables toward the pad cells (combinational gating of registered masks)
//   iso_o         1 = bank isolated/clamped
//   grp_en_o      registered driver group enable mask
//   ready_o       bank fully active
//   fault_o       sticky power loss indicator
//   state_o       current FSM state
module io_pad_pwr_seq
    import io_pad_seq_pkg::*;
#(
    parameter int unsigned NUM_GROUPS     = 4,
    parameter int unsigned GROUP_W        = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         pwr_ok_ai,
    input  logic                                         seq_start_i,
    input  logic                                         seq_stop_i,
    input  logic [bank_width(NUM_GROUPS, GROUP_W)-1:0]   core_oe_i,
    input  logic [bank_width(NUM_GROUPS, GROUP_W)-1:0]   core_ie_i,
    output logic [bank_width(NUM_GROUPS, GROUP_W)-1:0]   pad_oe_o,
    output logic [bank_width(NUM_GROUPS, GROUP_W)-1:0]   pad_ie_o,
    output logic                                         iso_o,
    output logic [NUM_GROUPS-1:0]                        grp_en_o,
    output logic                                         ready_o,
    output logic                                         fault_o,
    output logic [2:0]                                   state_o
);

    localparam int unsigned NG      = NUM_GROUPS;
    localparam int unsigned BANK_W  = bank_width(NUM_GROUPS, GROUP_W);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > STAGGER_CYCLES) ? SETTLE_CYCLES
                                                                       : STAGGER_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

    logic             pwr_ok;
    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NG-1:0]    grp_q, grp_d;
    logic [NG-1:0]    grp_up, grp_dn;
    logic             iso_q, iso_d;
    logic             rx_q, rx_d;
    logic             rdy_q, rdy_d;
    logic             flt_q, flt_d;
    logic             powered_state;

    io_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_pwr_sync (
        .clk (clk),
        .rst (rst),
        .d   (pwr_ok_ai),
        .q   (pwr_ok)
    );

    // Mask is always a thermometer code from bit 0, so up/down steps are plain shifts.
    assign grp_up = (grp_q << 1) | NG'(1);
    assign grp_dn = grp_q >> 1;

    assign powered_state = (state_q == ST_SETTLE) || (state_q == ST_TX_UP) ||
                           (state_q == ST_ACTIVE) || (state_q == ST_TX_DOWN);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            grp_q   <= '0;
            iso_q   <= 1'b1;
            rx_q    <= 1'b0;
            rdy_q   <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            iso_q   <= iso_d;
            rx_q    <= rx_d;
            rdy_q   <= rdy_d;
            flt_q   <= flt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grp_d   = grp_q;
        iso_d   = iso_q;
        rx_d    = rx_q;
        rdy_d   = rdy_q;
        flt_d   = flt_q;

        if (powered_state && !pwr_ok) begin
            // Power loss: drop everything at once, wait for power to return.
            state_d = ST_WAIT_PWR;
            cnt_d   = '0;
            grp_d   = '0;
            iso_d   = 1'b1;
            rx_d    = 1'b0;
            rdy_d   = 1'b0;
            flt_d   = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (seq_start_i && !seq_stop_i) begin
                        state_d = ST_WAIT_PWR;
                        flt_d   = 1'b0;
                    end
                end
                ST_WAIT_PWR: begin
                    if (seq_stop_i) begin
                        state_d = ST_OFF;
                    end else if (pwr_ok) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (seq_stop_i) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        iso_d = 1'b0;
                        rx_d  = 1'b1;
                        grp_d = NG'(1);
                        if (grp_d[NG-1]) begin
                            state_d = ST_ACTIVE;
                            rdy_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_TX_UP;
                            cnt_d   = STAGGER_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_TX_UP, ST_ACTIVE: begin
                    if (seq_stop_i) begin
                        // Shutdown: highest enabled group drops immediately.
                        grp_d = grp_dn;
                        rdy_d = 1'b0;
                        if (grp_dn == '0) begin
                            state_d = ST_OFF;
                            iso_d   = 1'b1;
                            rx_d    = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_TX_DOWN;
                            cnt_d   = STAGGER_LOAD;
                        end
                    end else if (state_q == ST_TX_UP) begin
                        if (cnt_q == '0) begin
                            grp_d = grp_up;
                            if (grp_up[NG-1]) begin
                                state_d = ST_ACTIVE;
                                rdy_d   = 1'b1;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = STAGGER_LOAD;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_TX_DOWN: begin
                    if (cnt_q == '0) begin
                        grp_d = grp_dn;
                        if (grp_dn == '0) begin
                            state_d = ST_OFF;
                            iso_d   = 1'b1;
                            rx_d    = 1'b0;
                        end else begin
                            cnt_d = STAGGER_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    // Unreachable encodings recover to a safe, isolated OFF.
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    grp_d   = '0;
                    iso_d   = 1'b1;
                    rx_d    = 1'b0;
                    rdy_d   = 1'b0;
                end
            endcase
        end
    end

    // Per-group output enable gating.
    for (genvar g = 0; g < NG; g++) begin : g_oe_gate
        assign pad_oe_o[g*GROUP_W +: GROUP_W] = core_oe_i[g*GROUP_W +: GROUP_W]
                                                & {GROUP_W{grp_q[g]}};
    end

    assign pad_ie_o = core_ie_i & {BANK_W{rx_q}};

    assign iso_o    = iso_q;
    assign grp_en_o = grp_q;
    assign ready_o  = rdy_q;
    assign fault_o  = flt_q;
    assign state_o  = state_q;

endmodule
